// File: rtl/song_sequencer.sv
// Song sequencer: walks {song, beat} addresses through a synchronous song ROM
// and turns each 7-bit slot word into an output tone frequency in Hz.
module song_sequencer #(
    parameter int unsigned  BEAT_W    = 8,
    parameter int unsigned  NUM_SONGS = 4,
    parameter int unsigned  TICK_DIV  = 12_500_000,
    localparam int unsigned SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     play,
    input  logic                     pause,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [SONG_W-1:0]        song_sel,
    output logic [SONG_W+BEAT_W-1:0] rom_addr,
    input  logic [6:0]               rom_data,
    output logic [31:0]              tone,
    output logic                     playing,
    output logic [BEAT_W-1:0]        beat_idx,
    output logic                     song_done
);

    localparam int unsigned ADDR_W = SONG_W + BEAT_W;
    localparam int unsigned TICK_W = 32;
    localparam int unsigned NOTE_W = 6;
    localparam int unsigned TONE_W = 32;

    localparam logic [TONE_W-1:0] REST_HZ   = TONE_W'(100_000_000);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_PLAY,
        S_PAUSED
    } state_t;

    state_t              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                done_q, done_d;
    logic                playing_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                end_hit;

    // Note code + octave to frequency; codes outside 1..7 are rests and ignore octave.
    function automatic logic [TONE_W-1:0] note_hz(input logic [NOTE_W-1:0] note);
        logic [TONE_W-1:0] base;
        logic [TONE_W-1:0] hz;
        base = '0;
        case (note[3:0])
            4'd1:    base = TONE_W'(262);
            4'd2:    base = TONE_W'(294);
            4'd3:    base = TONE_W'(330);
            4'd4:    base = TONE_W'(349);
            4'd5:    base = TONE_W'(392);
            4'd6:    base = TONE_W'(440);
            4'd7:    base = TONE_W'(494);
            default: base = '0;
        endcase
        case (note[5:4])
            2'd0:    hz = base;
            2'd1:    hz = base << 1;
            2'd2:    hz = base << 2;
            default: hz = base >> 1;
        endcase
        if (base == '0) begin
            hz = REST_HZ;
        end
        return hz;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            song_q     <= '0;
            beat_q     <= '0;
            tick_q     <= '0;
            note_q     <= '0;
            tone_q     <= REST_HZ;
            done_q     <= 1'b0;
            playing_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            beat_q     <= beat_d;
            tick_q     <= tick_d;
            note_q     <= note_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
            playing_q  <= (state_d != S_IDLE);
            rom_addr_q <= {song_d, beat_d};
        end
    end

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        beat_d  = beat_q;
        tick_d  = tick_q;
        note_d  = note_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        end_hit = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            beat_d  = '0;
            tick_d  = '0;
            tone_d  = REST_HZ;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tone_d = REST_HZ;
                    if (play) begin
                        state_d = S_ADDR;
                        song_d  = song_sel;
                        beat_d  = '0;
                        tick_d  = '0;
                    end
                end
                S_ADDR: begin
                    state_d = S_WAIT;
                end
                // An end marker is never played; it ends the song on the spot.
                S_WAIT: begin
                    if (rom_data[6]) begin
                        tone_d  = REST_HZ;
                        end_hit = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                        note_d  = rom_data[NOTE_W-1:0];
                        tone_d  = note_hz(rom_data[NOTE_W-1:0]);
                        tick_d  = '0;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                        tone_d  = REST_HZ;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (beat_q == BEAT_LAST) begin
                            end_hit = 1'b1;
                        end else begin
                            beat_d  = beat_q + BEAT_W'(1);
                            state_d = S_ADDR;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_PAUSED: begin
                    tone_d = REST_HZ;
                    if (!pause) begin
                        state_d = S_PLAY;
                        tone_d  = note_hz(note_q);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tone_d  = REST_HZ;
                end
            endcase

            if (end_hit) begin
                if (loop_en) begin
                    beat_d  = '0;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                    tone_d  = REST_HZ;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign tone      = tone_q;
    assign playing   = playing_q;
    assign beat_idx  = beat_q;
    assign song_done = done_q;

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter BEAT_W, default 8, width of the beat index (song length up to 2^BEAT_W quarter-beat slots).
REQ-002 SHALL have parameter NUM_SONGS, default 4, number of selectable songs; SONG_W = clog2(NUM_SONGS), minimum 1.
REQ-003 SHALL have parameter TICK_DIV, default 12_500_000, clock cycles per quarter-beat in PLAY, legal range 1 to 2^32-1.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous, active-low reset
  play  in  1  start request, sampled in IDLE only
  pause  in  1  level; hold playback
  stop  in  1  abort to IDLE
  loop_en  in  1  1 = restart at slot 0 after the end
  song_sel  in  SONG_W  song to play, latched on start
  rom_addr  out  SONG_W+BEAT_W  registered {song, beat} address to the synchronous song ROM
  rom_data  in  7  [3:0] note code, [5:4] octave, [6] end marker; valid 1 cycle after rom_addr is sampled
  tone  out  32  registered output frequency in Hz
  playing  out  1  high in ADDR, WAIT, PLAY, PAUSED
  beat_idx  out  BEAT_W  current slot index
  song_done  out  1  one-cycle pulse on a non-looping end

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, WAIT, PLAY, PAUSED.
REQ-006 SHALL resolve simultaneous controls with priority stop > pause > play.
REQ-007 SHALL go IDLE->ADDR when play=1 and stop=0, latch song_sel, and set beat_idx=0; play SHALL be ignored in every other state.
REQ-008 SHALL drive rom_addr={latched song, beat_idx} from entry to ADDR onward; ADDR->WAIT->PLAY take one cycle each.
REQ-009 SHALL register tone and the note register from rom_data on the WAIT->PLAY edge; tone SHALL hold its previous value during ADDR/WAIT (no rest glitch between slots).
REQ-010 SHALL map note codes 1..7 to 262, 294, 330, 349, 392, 440, 494 Hz; codes 0 and 8..15 SHALL be rest = 100_000_000.
REQ-011 SHALL apply octave to non-rest notes: 0 = base, 1 = base<<1, 2 = base<<2, 3 = base>>1 (truncated); rest SHALL ignore octave.
REQ-012 SHALL count TICK_DIV cycles in PLAY per slot, so one slot period is TICK_DIV+2 cycles.
REQ-013 SHALL, at tick terminal count, increment beat_idx and go to ADDR, unless beat_idx = 2^BEAT_W-1, which is the end condition.
REQ-014 SHALL treat rom_data[6]=1 sampled in WAIT as the end condition immediately: the slot is not played and tone = rest.
REQ-015 SHALL, on the end condition with loop_en=1, set beat_idx=0 and go to ADDR with no song_done pulse.
REQ-016 SHALL, on the end condition with loop_en=0, go to IDLE, set tone=rest, and pulse song_done for exactly one cycle.
REQ-017 SHALL go PLAY->PAUSED when pause=1, freeze the tick counter and beat_idx, and output tone=rest while in PAUSED.
REQ-018 SHALL go PAUSED->PLAY when pause=0, restore tone from the note register, and resume the tick count where it was frozen.
REQ-019 SHALL let a pause raised during ADDR/WAIT take effect on the first PLAY cycle; the fetch SHALL complete.
REQ-020 SHALL, on stop=1 in any state, go to IDLE next cycle with tone=rest, beat_idx=0, and no song_done pulse.
REQ-021 SHALL output tone=rest in IDLE.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set state=IDLE, tone=100_000_000, playing=0, beat_idx=0, rom_addr=0, song_done=0, tick counter=0, and the latched song to 0.
REQ-023 SHALL let reset override all other inputs, including mid-song, and SHALL never emit song_done because of reset.

Verification (TICK_DIV=4, BEAT_W=3, NUM_SONGS=2)
REQ-024 Song 1 slot 0 = {oct 0, note 6}, play pulse at cycle N -> rom_addr=8 from N+1, tone=440 from N+3, playing=1.
REQ-025 Slot data {oct 1, note 1} then {oct 3, note 5}, then code 9 -> tones 524, 196, 100_000_000; each held TICK_DIV+2=6 cycles.
REQ-026 End marker at slot 3: with loop_en=0 -> song_done high exactly 1 cycle, IDLE, tone=rest; with loop_en=1 -> beat_idx 3->0 and no pulse.
REQ-027 pause for 10 cycles mid-slot at tone 330 -> rest for 10 cycles, beat_idx frozen; after release, 330 resumes for the remaining tick count only.
REQ-028 stop, pause, and play asserted together in PLAY -> IDLE next cycle; play asserted in PLAY -> no restart, beat_idx unaffected.
REQ-029 rst_n=0 during PLAY at slot 5 -> all outputs at reset values next edge; no song_done pulse.
